seg7_decoder: RTL and testbench

Inverse of the hex seven-segment encoder. Samples a time-multiplexed, active-low seven-segment bus (segment pattern plus one-hot digit select), debounces each digit across scans, and decodes each pattern back to a hex nibble with blank and error flags. Publishes the decoded frame through a valid/ready handshake. Sits beside the display path so the board can read back, self-check, or log what the HEX displays actually show.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_lookup.sv | 35 +++
 rtl/seg7_decoder.sv | 128 ++++++++++++
 tb/tb_seg7_decoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment glyph constants and decode types.
// Used by both the display encoder and the readback decoder.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } dec_t;

  localparam dec_t DEC_BLANK = '{
    nibble: 4'h0,
    blank:  1'b1,
    err:    1'b0
  };

endpackage

// File: rtl/seg7_lookup.sv
// seg7_lookup: combinational active-low pattern to nibble decode.
// Unknown patterns decode to nibble 0 with the error flag set.
module seg7_lookup
  import seg7_pkg::*;
(
  input  seg_t seg,
  output dec_t dec
);

  // Pattern match against the glyph table
  always_comb begin
    dec = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
    case (seg)
      SEG_0:     dec.nibble = 4'h0;
      SEG_1:     dec.nibble = 4'h1;
      SEG_2:     dec.nibble = 4'h2;
      SEG_3:     dec.nibble = 4'h3;
      SEG_4:     dec.nibble = 4'h4;
      SEG_5:     dec.nibble = 4'h5;
      SEG_6:     dec.nibble = 4'h6;
      SEG_7:     dec.nibble = 4'h7;
      SEG_8:     dec.nibble = 4'h8;
      SEG_9:     dec.nibble = 4'h9;
      SEG_A:     dec.nibble = 4'hA;
      SEG_B:     dec.nibble = 4'hB;
      SEG_C:     dec.nibble = 4'hC;
      SEG_D:     dec.nibble = 4'hD;
      SEG_E:     dec.nibble = 4'hE;
      SEG_F:     dec.nibble = 4'hF;
      SEG_BLANK: dec.blank  = 1'b1;
      default:   dec.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_decoder.sv
// seg7_decoder: reads back a multiplexed seven-segment bus.
// Define SEG7_DEBOUNCE_EN to require STABLE_CNT matching scans.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    seg_strobe,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  dec_t dec;
  logic sel_ok;
  logic dirty;
  logic load;

  logic [NUM_DIGITS-1:0]   commit;
  logic [4*NUM_DIGITS-1:0] comm_val;
  logic [NUM_DIGITS-1:0]   comm_blank;
  logic [NUM_DIGITS-1:0]   comm_err;

  seg7_lookup u_lookup (
    .seg (seg_in),
    .dec (dec)
  );

  assign sel_ok = $onehot(dig_sel);

`ifdef SEG7_DEBOUNCE_EN
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
`else
  logic unused_cfg;
  assign unused_cfg = (STABLE_CNT != 0);
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    dec_t comm;
    logic hit;

    assign hit = seg_strobe && sel_ok && dig_sel[i];

`ifdef SEG7_DEBOUNCE_EN
    dec_t       cand;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       match;
    logic       reach;

    assign match   = (dec == cand);
    assign cnt_nxt = !match          ? 4'd1 :
                     (cnt == CNT_MAX) ? cnt  :
                                        cnt + 4'd1;
    // Commit only on the scan that first reaches the threshold
    assign reach = (cnt_nxt == CNT_MAX) &&
                   (!match || cnt != CNT_MAX);
    assign commit[i] = hit && reach && (dec != comm);

    // Candidate and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand <= DEC_BLANK;
        cnt  <= 4'd0;
      end else if (hit) begin
        cand <= dec;
        cnt  <= cnt_nxt;
      end
    end
`else
    assign commit[i] = hit && (dec != comm);
`endif

    // Committed digit value
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        comm <= DEC_BLANK;
      end else if (commit[i]) begin
        comm <= dec;
      end
    end

    assign comm_val[4*i +: 4] = comm.nibble;
    assign comm_blank[i]      = comm.blank;
    assign comm_err[i]        = comm.err;
  end

  assign load = dirty && (!out_valid || out_ready);

  // Output frame register; a same-cycle commit stays dirty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_out <= '0;
      blank_out <= '1;
      err_out   <= '0;
      out_valid <= 1'b0;
      dirty     <= 1'b0;
    end else begin
      if (load) begin
        value_out <= comm_val;
        blank_out <= comm_blank;
        err_out   <= comm_err;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      dirty <= (dirty && !load) || (|commit);
    end
  end

  // Flag strobes whose digit select is not one-hot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= seg_strobe && !sel_ok;
    end
  end

endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: directed steps with a frame scoreboard.
// Expected frames are pushed when a strobe should commit.
module tb_seg7_decoder;

  localparam int N = 6;
`ifdef SEG7_DEBOUNCE_EN
  localparam int K = 4;
`else
  localparam int K = 1;
`endif

  typedef struct packed {
    logic [23:0] val;
    logic [5:0]  blank;
    logic [5:0]  err;
  } frame_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       b;
    logic       e;
  } mdec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic [N-1:0]  dig_sel;
  logic          seg_strobe;
  logic [4*N-1:0] value_out;
  logic [N-1:0]  blank_out;
  logic [N-1:0]  err_out;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;

  int tests = 0;
  int fails = 0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  mdec_t  m_cand [N];
  mdec_t  m_comm [N];
  int     m_cnt  [N];
  frame_t q [$];
  frame_t mon_got;
  frame_t mon_exp;
  logic [23:0] held;

  seg7_decoder #(
    .NUM_DIGITS (N),
    .STABLE_CNT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .seg_strobe (seg_strobe),
    .value_out  (value_out),
    .blank_out  (blank_out),
    .err_out    (err_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  function automatic mdec_t ref_dec(input logic [6:0] s);
    mdec_t r;
    r = '{nib: 4'h0, b: 1'b0, e: 1'b1};
    if (s == 7'h7f) r = '{nib: 4'h0, b: 1'b1, e: 1'b0};
    for (int k = 0; k < 16; k++)
      if (s == glyph[k]) r = '{nib: 4'(k), b: 1'b0, e: 1'b0};
    return r;
  endfunction

  function automatic frame_t snap();
    frame_t f;
    for (int d = 0; d < N; d++) begin
      f.val[4*d +: 4] = m_comm[d].nib;
      f.blank[d]      = m_comm[d].b;
      f.err[d]        = m_comm[d].e;
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_cand[d] = '{nib: 4'h0, b: 1'b1, e: 1'b0};
      m_comm[d] = '{nib: 4'h0, b: 1'b1, e: 1'b0};
      m_cnt[d]  = 0;
    end
  endtask

  task automatic model_strobe(input int d, input logic [6:0] s);
    mdec_t r;
    int    prev;
    int    nxt;
    logic  reach;
    r    = ref_dec(s);
    prev = m_cnt[d];
    if (r == m_cand[d]) begin
      nxt   = (prev < K) ? prev + 1 : prev;
      reach = (nxt == K) && (prev != K);
    end else begin
      nxt   = 1;
      reach = (K == 1);
    end
    m_cand[d] = r;
    m_cnt[d]  = nxt;
    if (reach && r != m_comm[d]) begin
      m_comm[d] = r;
      q.push_back(snap());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic strobe(input int d, input logic [6:0] s);
    @(posedge clk);
    #1;
    dig_sel    = N'(1 << d);
    seg_in     = s;
    seg_strobe = 1'b1;
    model_strobe(d, s);
    @(posedge clk);
    #1;
    seg_strobe = 1'b0;
    dig_sel    = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && q.size() != 0; i++)
      @(posedge clk);
    @(negedge clk);
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: every transfer must match the oldest expected frame
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_got = {value_out, blank_out, err_out};
      tests++;
      if (q.size() == 0) begin
        assert (q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_frame got=%h exp=none", mon_got);
        end
      end else begin
        mon_exp = q.pop_front();
        assert (mon_got === mon_exp) else begin
          fails++;
          $error("FAIL frame got=%h exp=%h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    seg_in     = 7'h7f;
    dig_sel    = '0;
    seg_strobe = 1'b0;
    out_ready  = 1'b1;
    model_reset();
    #22;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_blank", 32'(blank_out), 32'h3f);
    chk("rst_value", 32'(value_out), 32'd0);
    chk("rst_err",   32'(err_out),   32'd0);
    chk("rst_selerr", 32'(sel_err),  32'd0);

    // Digit 2 shows '2'
    for (int n = 0; n < 3; n++) strobe(2, 7'b0100100);
    @(negedge clk);
    chk("d2_after3_valid", 32'(out_valid), 32'd0);
    drain("d2_after3_q");
    strobe(2, 7'b0100100);
    drain("d2_commit_q");
    chk("d2_nibble", 32'(value_out[11:8]), 32'h2);
    chk("d2_blank",  32'(blank_out[2]),    32'd0);
    strobe(2, 7'b0100100);
    drain("d2_fifth_q");
    chk("d2_fifth_valid", 32'(out_valid), 32'd0);

    // Digit 0 flickers between 6 and b, then settles on b
    for (int n = 0; n < 20; n++)
      strobe(0, n[0] ? 7'b0000011 : 7'b0000010);
    drain("d0_flicker_q");
    for (int n = 0; n < 4; n++) strobe(0, 7'b0000011);
    drain("d0_settle_q");
    chk("d0_nibble", 32'(value_out[3:0]), 32'hb);

    // Digit 1 shows an illegal pattern
    for (int n = 0; n < 4; n++) strobe(1, 7'b1010101);
    drain("d1_err_q");
    chk("d1_err",    32'(err_out[1]),     32'd1);
    chk("d1_nibble", 32'(value_out[7:4]), 32'd0);

    // Consumer stalls while digits 3 and 4 commit
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) strobe(3, 7'b1111000);
    for (int n = 0; n < 4; n++) strobe(4, 7'b0001110);
    @(negedge clk);
    held = value_out;
    chk("hold_valid", 32'(out_valid),        32'd1);
    chk("hold_d3",    32'(value_out[15:12]), 32'h7);
    chk("hold_d4_bl", 32'(blank_out[4]),     32'd1);
    chk("hold_qlen",  32'(q.size()),         32'd2);
    repeat (5) @(negedge clk);
    chk("hold_stable", 32'(value_out), 32'(held));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("release_q");
    chk("release_d34", 32'(value_out[19:12]), 32'hf7);
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 32'd0);

    // Multi-hot select is ignored and flagged
    held = value_out;
    @(posedge clk);
    #1;
    dig_sel    = 6'b000011;
    seg_in     = 7'b1111001;
    seg_strobe = 1'b1;
    @(posedge clk);
    #1;
    seg_strobe = 1'b0;
    dig_sel    = '0;
    chk("selerr_pulse", 32'(sel_err), 32'd1);
    @(posedge clk);
    #1;
    chk("selerr_clear", 32'(sel_err), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("selerr_value", 32'(value_out), 32'(held));
    chk("selerr_valid", 32'(out_valid), 32'd0);

    // Reset while a frame is pending
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) strobe(5, 7'b1000000);
    @(negedge clk);
    chk("pend_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_blank", 32'(blank_out), 32'h3f);
    chk("midrst_value", 32'(value_out), 32'd0);
    q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Recovery after reset
    for (int n = 0; n < 4; n++) strobe(1, 7'b1111001);
    drain("post_rst_q");
    chk("post_rst_d1", 32'(value_out[7:4]), 32'h1);
    chk("post_rst_bl", 32'(blank_out),      32'h3d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
